// File: rtl/btn_pkg.sv
// Shared definitions for the button PIO poller: FSM states, PIO register map
// and the counter-width helper used by the debounce and repeat timers.
package btn_pkg;

    typedef enum logic [3:0] {
        INIT,
        IDLE,
        DB_P,
        RD_P,
        CAP_P,
        HELD,
        DB_R,
        RD_R,
        CAP_R
    } btn_state_t;

    localparam logic [1:0]  DATA        = 2'd0;
    localparam logic [1:0]  MASK        = 2'd2;
    localparam logic [31:0] IRQ_MASK_ON = 32'd1;

    // Width of a counter holding n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_timer.sv
// Loadable saturating down-counter with a zero flag.
module btn_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/btn_pio_poller.sv
// Avalon-MM initiator that arms the button PIO interrupt, debounces presses
// and releases by re-reading the PIO data register, and generates auto-repeat.
module btn_pio_poller
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        irq,
    input  logic [31:0] readdata,
    output logic [1:0]  address,
    output logic        chipselect,
    output logic        write_n,
    output logic [31:0] writedata,
    output logic        press_pulse,
    output logic        pressed
);

    localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RP_W = cnt_width(REPEAT_CYCLES);
    localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_LOAD = RP_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

    btn_state_t r_state;
    btn_state_t w_next;

    logic [1:0]  r_address;
    logic        r_chipselect;
    logic        r_write_n;
    logic [31:0] r_writedata;
    logic        r_press_pulse;
    logic        r_pressed;

    logic [1:0]  w_address;
    logic        w_chipselect;
    logic        w_write_n;
    logic [31:0] w_writedata;
    logic        w_pulse;
    logic        w_pressed;

    logic w_db_load;
    logic w_db_dec;
    logic w_db_zero;
    logic w_rp_load;
    logic w_rp_dec;
    logic w_rp_zero;

    // Only the button bit of the data register is meaningful.
    logic w_unused_rd;
    assign w_unused_rd = ^readdata[31:1];

    btn_timer #(
        .WIDTH (DB_W)
    ) u_db_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_db_load),
        .i_load_val (DB_LOAD),
        .i_dec      (w_db_dec),
        .o_zero     (w_db_zero)
    );

    btn_timer #(
        .WIDTH (RP_W)
    ) u_rp_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_rp_load),
        .i_load_val (RP_LOAD),
        .i_dec      (w_rp_dec),
        .o_zero     (w_rp_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_address    = '0;
        w_chipselect = 1'b0;
        w_write_n    = 1'b1;
        w_writedata  = '0;
        w_pulse      = 1'b0;
        w_pressed    = r_pressed;
        w_db_load    = 1'b0;
        w_db_dec     = 1'b0;
        w_rp_load    = 1'b0;
        w_rp_dec     = 1'b0;

        case (r_state)
            INIT: begin
                w_address    = MASK;
                w_chipselect = 1'b1;
                w_write_n    = 1'b0;
                w_writedata  = IRQ_MASK_ON;
                w_next       = IDLE;
            end
            IDLE: begin
                if (irq && enable) begin
                    w_db_load = 1'b1;
                    w_next    = DB_P;
                end
            end
            DB_P: begin
                if (w_db_zero) begin
                    w_next = RD_P;
                end else begin
                    w_db_dec = 1'b1;
                end
            end
            RD_P: begin
                w_address    = DATA;
                w_chipselect = 1'b1;
                w_next       = CAP_P;
            end
            CAP_P: begin
                if (readdata[0]) begin
                    w_pressed = 1'b1;
                    w_pulse   = 1'b1;
                    w_rp_load = 1'b1;
                    w_next    = HELD;
                end else begin
                    w_next = IDLE;
                end
            end
            HELD: begin
                // Release takes priority over a repeat expiring in the same cycle.
                if (!irq) begin
                    w_db_load = 1'b1;
                    w_next    = DB_R;
                end else if (REPEAT_CYCLES != 0) begin
                    if (w_rp_zero) begin
                        w_pulse   = 1'b1;
                        w_rp_load = 1'b1;
                    end else begin
                        w_rp_dec = 1'b1;
                    end
                end
            end
            DB_R: begin
                if (w_db_zero) begin
                    w_next = RD_R;
                end else begin
                    w_db_dec = 1'b1;
                end
            end
            RD_R: begin
                w_address    = DATA;
                w_chipselect = 1'b1;
                w_next       = CAP_R;
            end
            CAP_R: begin
                if (!readdata[0]) begin
                    w_pressed = 1'b0;
                    w_next    = IDLE;
                end else begin
                    w_next = HELD;
                end
            end
            default: begin
                w_next = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_address     <= '0;
            r_chipselect  <= 1'b0;
            r_write_n     <= 1'b1;
            r_writedata   <= '0;
            r_press_pulse <= 1'b0;
            r_pressed     <= 1'b0;
        end else begin
            r_address     <= w_address;
            r_chipselect  <= w_chipselect;
            r_write_n     <= w_write_n;
            r_writedata   <= w_writedata;
            // Suppression keeps pulses isolated even with a one-cycle repeat period.
            r_press_pulse <= w_pulse & ~r_press_pulse;
            r_pressed     <= w_pressed;
        end
    end

    assign address     = r_address;
    assign chipselect  = r_chipselect;
    assign write_n     = r_write_n;
    assign writedata   = r_writedata;
    assign press_pulse = r_press_pulse;
    assign pressed     = r_pressed;

endmodule

// File: tb/tb_btn_pio_poller.sv
// Directed bench for btn_pio_poller with a cycle-stamped scoreboard of bus
// accesses and press pulses.
module tb_btn_pio_poller;

    localparam int unsigned D = 4;
    localparam int unsigned R = 10;

    localparam int K_WRITE = 0;
    localparam int K_READ  = 1;
    localparam int K_PULSE = 2;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        irq;
    logic [31:0] readdata;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic        press_pulse;
    logic        pressed;

    btn_pio_poller #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .irq         (irq),
        .readdata    (readdata),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .press_pulse (press_pulse),
        .pressed     (pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        logic [1:0]  addr;
        logic [31:0] wdata;
    } evt_t;

    evt_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev_pulse = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int kind, input logic [1:0] a, input logic [31:0] wd);
        evt_t e;
        e.cyc   = c;
        e.kind  = kind;
        e.addr  = a;
        e.wdata = wd;
        sb.push_back(e);
    endtask

    task automatic check_evt(input int kind);
        evt_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL sb_unexpected: observed event kind %0d at cycle %0d, expected none", kind, cyc);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("evt_cycle", cyc, e.cyc);
            chk("evt_kind", kind, e.kind);
            if (kind != K_PULSE) begin
                chk("evt_addr", {30'd0, address}, {30'd0, e.addr});
                chk("evt_wdata", writedata, e.wdata);
            end
        end
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("sb_missed", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (chipselect) check_evt(write_n ? K_READ : K_WRITE);
        if (press_pulse) begin
            chk("pulse_isolated", {31'd0, prev_pulse}, 32'd0);
            check_evt(K_PULSE);
        end
        prev_pulse = press_pulse;
    endtask

    task automatic tick_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic drain(input string tag);
        chk(tag, sb.size(), 0);
        sb.delete();
    endtask

    int k;
    int j;
    int p0;

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        irq      = 1'b0;
        readdata = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_cs",     {31'd0, chipselect}, 32'd0);
        chk("rst_wn",     {31'd0, write_n}, 32'd1);
        chk("rst_addr",   {30'd0, address}, 32'd0);
        chk("rst_wdata",  writedata, 32'd0);
        chk("rst_pulse",  {31'd0, press_pulse}, 32'd0);
        chk("rst_press",  {31'd0, pressed}, 32'd0);

        // Mask write on the first edge after release, then idle bus
        @(negedge clk);
        reset_n = 1'b1;
        push(cyc + 1, K_WRITE, 2'd2, 32'd1);
        repeat (6) tick();
        chk("init_press", {31'd0, pressed}, 32'd0);
        drain("init_drain");

        // Press held: read, pulse, repeats; release coincides with a repeat expiry
        enable   = 1'b1;
        k        = cyc;
        irq      = 1'b1;
        readdata = 32'd1;
        p0       = k + D + 3;
        push(k + D + 2, K_READ, 2'd0, 32'd0);
        push(p0,         K_PULSE, 2'd0, 32'd0);
        push(p0 + R,     K_PULSE, 2'd0, 32'd0);
        push(p0 + 2 * R, K_PULSE, 2'd0, 32'd0);
        tick_until(k + D + 2);
        chk("press_before_cap", {31'd0, pressed}, 32'd0);
        tick();
        chk("press_after_cap", {31'd0, pressed}, 32'd1);
        j = p0 + 3 * R - 1;
        tick_until(j);
        chk("press_held", {31'd0, pressed}, 32'd1);
        irq      = 1'b0;
        readdata = 32'd0;
        push(j + D + 2, K_READ, 2'd0, 32'd0);
        tick_until(j + D + 2);
        chk("rel_before_cap", {31'd0, pressed}, 32'd1);
        tick();
        chk("rel_after_cap", {31'd0, pressed}, 32'd0);
        repeat (5) tick();
        drain("hold_drain");

        // Glitch: irq high for two cycles, button reads low
        k        = cyc;
        irq      = 1'b1;
        readdata = 32'd0;
        push(k + D + 2, K_READ, 2'd0, 32'd0);
        repeat (2) tick();
        irq = 1'b0;
        tick_until(k + D + 3);
        chk("glitch_press", {31'd0, pressed}, 32'd0);
        repeat (5) tick();
        drain("glitch_drain");

        // Disabled: no activity; enabling starts a press that survives disable
        enable   = 1'b0;
        irq      = 1'b1;
        readdata = 32'd1;
        repeat (15) tick();
        drain("disabled_drain");
        chk("disabled_press", {31'd0, pressed}, 32'd0);
        k      = cyc;
        enable = 1'b1;
        push(k + D + 2, K_READ, 2'd0, 32'd0);
        push(k + D + 3, K_PULSE, 2'd0, 32'd0);
        tick();
        enable = 1'b0;
        tick_until(k + D + 3);
        chk("enable_press", {31'd0, pressed}, 32'd1);
        j        = cyc;
        irq      = 1'b0;
        readdata = 32'd0;
        push(j + D + 2, K_READ, 2'd0, 32'd0);
        tick_until(j + D + 3);
        chk("enable_release", {31'd0, pressed}, 32'd0);
        repeat (3) tick();
        drain("enable_drain");

        // Reset while the press read is on the bus
        enable   = 1'b1;
        k        = cyc;
        irq      = 1'b1;
        readdata = 32'd1;
        push(k + D + 2, K_READ, 2'd0, 32'd0);
        tick_until(k + D + 2);
        chk("midrd_cs", {31'd0, chipselect}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_cs",   {31'd0, chipselect}, 32'd0);
        chk("async_wn",   {31'd0, write_n}, 32'd1);
        chk("async_addr", {30'd0, address}, 32'd0);
        drain("midrd_drain");
        irq      = 1'b0;
        readdata = 32'd0;
        repeat (3) tick();
        chk("rst2_press", {31'd0, pressed}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        push(cyc + 1, K_WRITE, 2'd2, 32'd1);
        repeat (3) tick();
        chk("rst2_press_after", {31'd0, pressed}, 32'd0);
        drain("rst2_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
